// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480 timing, the sync/de bundle and
// helpers deriving line/frame totals and framebuffer depth.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int SCALE_LOG2_DEF = 2;
  localparam int PIX_W_DEF      = 3;

  // Active-high timing flags; polarity is applied only at the output pins.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_timing_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vga_fb_depth(input int h_active, input int v_active, input int scale_log2);
    return (h_active >> scale_log2) * (v_active >> scale_log2);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage-0 raster counters with sync/de decode and a one-clk frame_start pulse
// issued on the pix_en that consumes line 0, pixel 0.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output vga_timing_t   tim,
  output logic          frame_start
);

  localparam logic [HW-1:0] H_LAST   = HW'(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (hcnt == '0) && (vcnt == '0);
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  always_comb begin
    tim       = '0;
    tim.hsync = (hcnt >= HS_START) && (hcnt < HS_END);
    tim.vsync = (vcnt >= VS_START) && (vcnt < VS_END);
    tim.de    = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  end

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA controller with integrated scaled framebuffer and 2-stage pixel fetch.
// Optional VGA_FB_VBLANK_IRQ_EN adds irq_clr / sticky vblank_irq.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             wr_en,
  input  logic [15:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic [PIX_W-1:0] vga_rgb,
  output logic             frame_start
`ifdef VGA_FB_VBLANK_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             vblank_irq
`endif
);

  localparam int H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int FB_W     = H_ACTIVE >> SCALE_LOG2;
  localparam int FB_DEPTH = vga_fb_depth(H_ACTIVE, V_ACTIVE, SCALE_LOG2);
  localparam int AW       = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int HW       = $clog2(H_TOTAL + 1);
  localparam int VW       = $clog2(V_TOTAL + 1);
  localparam logic [VW-1:0] S_MASK = VW'((1 << SCALE_LOG2) - 1);

  logic [HW-1:0]    hcnt_p0;
  logic [VW-1:0]    vcnt_p0;
  vga_timing_t      tim_p0;
  logic [AW-1:0]    row_base_p0;
  logic             row_adv_p0;
  logic             frame_end_p0;
  logic [AW-1:0]    rd_addr_p1;
  vga_timing_t      tim_p1;
  vga_timing_t      tim_p2;
  logic [PIX_W-1:0] rgb_p2;
  logic [PIX_W-1:0] fb [FB_DEPTH];

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcnt       (hcnt_p0),
    .vcnt       (vcnt_p0),
    .tim        (tim_p0),
    .frame_start(frame_start)
  );

  // Stage 0: row base steps by one framebuffer row after the last screen line
  // of each scaled row, and is cleared as the raster wraps so line 0 starts at 0.
  assign row_adv_p0   = (hcnt_p0 == HW'(H_ACTIVE - 1)) && (vcnt_p0 < VW'(V_ACTIVE)) &&
                        ((vcnt_p0 & S_MASK) == S_MASK);
  assign frame_end_p0 = (hcnt_p0 == HW'(H_TOTAL - 1)) && (vcnt_p0 == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base_p0 <= '0;
    end else if (pix_en) begin
      if (frame_end_p0)    row_base_p0 <= '0;
      else if (row_adv_p0) row_base_p0 <= row_base_p0 + AW'(FB_W);
    end
  end

  // Read-first RAM: a same-edge display read sees the previous contents.
  always_ff @(posedge clk) begin
    if (wr_en && ({16'd0, wr_addr} < 32'(FB_DEPTH)))
      fb[wr_addr[AW-1:0]] <= wr_data;
  end

  // Stage 1: registered read address alongside delayed timing.
  always_ff @(posedge clk) begin
    if (pix_en) rd_addr_p1 <= row_base_p0 + AW'(hcnt_p0 >> SCALE_LOG2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tim_p1 <= '0;
      tim_p2 <= '0;
      rgb_p2 <= '0;
    end else if (pix_en) begin
      tim_p1 <= tim_p0;
      // Stage 2: RAM data out, blanked outside the visible area.
      tim_p2 <= tim_p1;
      rgb_p2 <= tim_p1.de ? fb[rd_addr_p1] : '0;
    end
  end

  assign vga_hsync = tim_p2.hsync ? SYNC_POL : ~SYNC_POL;
  assign vga_vsync = tim_p2.vsync ? SYNC_POL : ~SYNC_POL;
  assign vga_de    = tim_p2.de;
  assign vga_rgb   = rgb_p2;

`ifdef VGA_FB_VBLANK_IRQ_EN
  logic vbl_p1;

  // Set coincides with stage 2 reaching line V_ACTIVE, pixel 0; set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vbl_p1     <= 1'b0;
      vblank_irq <= 1'b0;
    end else begin
      if (pix_en) vbl_p1 <= (hcnt_p0 == '0) && (vcnt_p0 == VW'(V_ACTIVE));
      if (pix_en && vbl_p1) vblank_irq <= 1'b1;
      else if (irq_clr)     vblank_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Bench for vga_fb_ctrl on a reduced 24x17 raster (16x12 visible, 4x3 framebuffer).
// A raster-position model predicts every output each cycle; directed literals pin it.
module tb_vga_fb_ctrl;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int SC = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FBW = HA >> SC;
  localparam int DEPTH = FBW * (VA >> SC);
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = 16'd0;
  logic [2:0]  wr_data = 3'd0;
  logic        vga_hsync, vga_vsync, vga_de, frame_start;
  logic [2:0]  vga_rgb;
`ifdef VGA_FB_VBLANK_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        vblank_irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_fb_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SCALE_LOG2(SC), .PIX_W(3), .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_de     (vga_de),
    .vga_rgb    (vga_rgb),
    .frame_start(frame_start)
`ifdef VGA_FB_VBLANK_IRQ_EN
    ,
    .irq_clr    (irq_clr),
    .vblank_irq (vblank_irq)
`endif
  );

  // Model: raster position, framebuffer image, and positions in flight.
  logic [2:0] fb_m [DEPTH];
  int mh = 0, mv = 0;
  int q_h[$], q_v[$];
  logic exp_hs = 1'b0, exp_vs = 1'b0, exp_de = 1'b0, exp_fs = 1'b0, exp_irq = 1'b0;
  logic [2:0] exp_rgb = 3'd0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mh = 0; mv = 0;
        q_h.delete(); q_v.delete();
        exp_hs = 1'b0; exp_vs = 1'b0; exp_de = 1'b0; exp_fs = 1'b0; exp_rgb = 3'd0; exp_irq = 1'b0;
      end else begin
        logic set_irq;
        set_irq = 1'b0;
        exp_fs = pix_en && mh == 0 && mv == 0;
        if (pix_en) begin
          q_h.push_back(mh); q_v.push_back(mv);
          if (q_h.size() > 2) begin
            void'(q_h.pop_front()); void'(q_v.pop_front());
          end
          if (q_h.size() == 2) begin
            int h, v;
            h = q_h[0]; v = q_v[0];
            exp_hs  = h >= HA + HF && h < HA + HF + HS;
            exp_vs  = v >= VA + VF && v < VA + VF + VS;
            exp_de  = h < HA && v < VA;
            exp_rgb = exp_de ? fb_m[(v >> SC) * FBW + (h >> SC)] : 3'd0;
            set_irq = (h == 0 && v == VA);
          end
          mh++;
          if (mh == HT) begin
            mh = 0; mv++;
            if (mv == VT) mv = 0;
          end
        end
`ifdef VGA_FB_VBLANK_IRQ_EN
        exp_irq = set_irq | (exp_irq & ~irq_clr);
`endif
        if (wr_en && int'(wr_addr) < DEPTH) fb_m[wr_addr] = wr_data;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      logic [6:0] got, want;
      @(negedge clk);
      got  = {vga_hsync, vga_vsync, vga_de, vga_rgb, frame_start};
      want = {~exp_hs, ~exp_vs, exp_de, exp_rgb, exp_fs};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t pos=%0d,%0d got=%b want=%b", $time, mh, mv, got, want);
      end
`ifdef VGA_FB_VBLANK_IRQ_EN
      n_vec++;
      if (vblank_irq !== exp_irq) begin
        n_err++;
        $display("FAIL cycle_irq t=%0t got=%b want=%b", $time, vblank_irq, exp_irq);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wr(input int a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = 16'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pos(input string name, input int h, input int v);
    int i;
    for (i = 0; i < 2 * FRAME && !(mh == h && mv == v); i++) @(negedge clk);
    check(name, 32'(mh == h && mv == v), 32'd1);
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low, vs_low, de_hi, c101, c110, fs_n, f1, f2;
    logic prev_hs;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hsync", 32'(vga_hsync), 32'd1);
    check("rst_vsync", 32'(vga_vsync), 32'd1);
    check("rst_de", 32'(vga_de), 32'd0);
    check("rst_rgb", 32'(vga_rgb), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
`ifdef VGA_FB_VBLANK_IRQ_EN
    check("rst_irq", 32'(vblank_irq), 32'd0);
`endif
    reset = 1'b1;

    for (int a = 0; a < DEPTH; a++) wr(a, 3'd0);
    wr(5, 3'b101);
    wr(DEPTH - 1, 3'b110);
    wr(DEPTH, 3'b111);
    wr(21, 3'b111);

    // Two full frames at pix_en every clk.
    hs_low = 0; vs_low = 0; de_hi = 0; c101 = 0; c110 = 0; fs_n = 0; f1 = -1; f2 = -1;
    prev_hs = 1'b1;
    pix_en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (vga_de) de_hi++;
      if (vga_rgb == 3'b101) c101++;
      if (vga_rgb == 3'b110) c110++;
      if (frame_start) fs_n++;
      if (prev_hs && !vga_hsync) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      prev_hs = vga_hsync;
    end
    check("hsync_low_clks", 32'(hs_low), 32'd102);
    check("vsync_low_clks", 32'(vs_low), 32'd96);
    check("de_high_clks", 32'(de_hi), 32'd384);
    check("pix_101_count", 32'(c101), 32'd32);
    check("pix_110_count", 32'(c110), 32'd32);
    check("frame_start_count", 32'(fs_n), 32'd2);
    check("hsync_period", 32'(f2 - f1), 32'd24);

    // pix_en on alternate clks; a write lands mid-scan.
    f1 = -1; f2 = -1; prev_hs = vga_hsync;
    for (int i = 0; i < 200; i++) begin
      pix_en = ~pix_en;
      if (i == 50) begin wr_en = 1'b1; wr_addr = 16'd0; wr_data = 3'b011; end
      if (i == 51) wr_en = 1'b0;
      @(negedge clk);
      if (prev_hs && !vga_hsync) begin
        if (f1 < 0) f1 = i;
        else if (f2 < 0) f2 = i;
      end
      prev_hs = vga_hsync;
    end
    check("hsync_period_half_rate", 32'(f2 - f1), 32'd48);

    // Asynchronous reset in the middle of the visible block at (5,5).
    pix_en = 1'b1;
    wait_pos("reach_7_5", 7, 5);
    check("pre_reset_rgb", 32'(vga_rgb), 32'b101);
    check("pre_reset_de", 32'(vga_de), 32'd1);
    #2 reset = 1'b0;
    pix_en = 1'b0;
    #1;
    check("async_rst_de", 32'(vga_de), 32'd0);
    check("async_rst_rgb", 32'(vga_rgb), 32'd0);
    check("async_rst_hv", 32'({vga_hsync, vga_vsync}), 32'b11);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("fs_before_en", 32'(frame_start), 32'd0);
    pix_en = 1'b1;
    @(negedge clk);
    check("fs_first_en", 32'(frame_start), 32'd1);
    @(negedge clk);
    check("fs_one_clk", 32'(frame_start), 32'd0);

`ifdef VGA_FB_VBLANK_IRQ_EN
    wait_pos("reach_1_12", 1, VA);
    check("irq_before_set", 32'(vblank_irq), 32'd0);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_set_wins", 32'(vblank_irq), 32'd1);
    repeat (5) @(negedge clk);
    check("irq_sticky", 32'(vblank_irq), 32'd1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_cleared", 32'(vblank_irq), 32'd0);
`endif
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_ctrl.md
# vga_fb_ctrl

Parametrised VGA display controller with an integrated, dual-ported, scaled framebuffer.
It generates sync and data-enable timing, fetches pixels through a fixed 2-stage pipeline, and accepts CPU byte writes on the same clock.
It replaces the fixed 640x480 timing block plus separate 8-bit video RAM in the SoC top; the SoC decodes the CPU store address and drives `wr_en`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `SCALE_LOG2`, 2, each framebuffer pixel covers a 2^SCALE_LOG2 square of screen pixels
- `PIX_W`, 3, colour bits per pixel (1..8)
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel clock enable; all timing advances only when high
- `wr_en`  in  1  CPU framebuffer write strobe
- `wr_addr`  in  16  framebuffer word address, linear, row-major
- `wr_data`  in  PIX_W  pixel value to write
- `vga_hsync`  out  1  horizontal sync
- `vga_vsync`  out  1  vertical sync
- `vga_de`  out  1  data enable, high in the visible area
- `vga_rgb`  out  PIX_W  pixel data; forced to 0 when `vga_de` is low
- `frame_start`  out  1  one-`clk` pulse on the first `pix_en` of line 0, pixel 0

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - FB_W = H_ACTIVE>>SCALE_LOG2; FB_H = V_ACTIVE>>SCALE_LOG2; FB_DEPTH = FB_W*FB_H.
- Counters `hcnt` and `vcnt` advance on `pix_en`.
  - `hcnt` wraps from H_TOTAL-1 to 0.
  - `vcnt` increments on that wrap and itself wraps from V_TOTAL-1 to 0.
- hsync is active when hcnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the same rule on `vcnt`.
- de is high when hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Address generation uses no multiplier:
  - `row_base` is reset to 0 at vcnt = 0.
  - `row_base` advances by FB_W at the end of each visible line where the low SCALE_LOG2 bits of vcnt are all 1.
  - `col` = hcnt>>SCALE_LOG2; read address = row_base + col.
- Framebuffer: FB_DEPTH x PIX_W, one write port and one read port, read-first.
  - Same-cycle write and read to one address returns the old data.
- A write with wr_addr ≥ FB_DEPTH is ignored.
- Writes are accepted on every `clk` edge regardless of `pix_en` or display position. There is no stall and no back-pressure.

## Timing
- Pipeline stage 0: counters. Stage 1: registered read address plus delayed sync/de. Stage 2: RAM data out plus delayed sync/de.
  - All outputs are registered and aligned at stage 2.
  - Latency is 2 `pix_en` cycles from counter state to outputs.
- Pipeline registers advance only when `pix_en` is high; outputs hold otherwise.
- Reset values:
  - hcnt = vcnt = row_base = 0.
  - `vga_hsync` = `vga_vsync` = inactive level (~SYNC_POL).
  - `vga_de` = 0, `vga_rgb` = 0, `frame_start` = 0.
- Framebuffer contents are not reset.
- Reset asserted mid-frame returns all counters and pipeline stages to the reset state immediately (asynchronous). The first frame after release starts at 0,0.
- A write completes in 1 `clk` cycle. Its data is visible to any display read issued on the following edge.

## Configuration
- `VGA_FB_VBLANK_IRQ_EN` defined adds two ports:
  - `irq_clr` in 1.
  - `vblank_irq` out 1, a sticky flag set when the stage-2 vcnt reaches V_ACTIVE at hcnt 0.
  - `irq_clr` clears the flag; if set and clear coincide, set wins.
  - The flag resets to 0.
- Without the macro, neither port exists and no flag logic is built.

## Structure
- Shared package `vga_pkg`:
  - Default timing constants.
  - `vga_timing_t` struct (hsync, vsync, de).
  - Function computing H_TOTAL/V_TOTAL/FB_DEPTH.
  - Address width is $clog2(FB_DEPTH), zero-extended from `wr_addr`.
- One sub-module, `vga_timing`: counters, sync/de decode, `frame_start`.
- The framebuffer array and pipeline stay in the top-level block.

## Test plan
- Default params, `pix_en` = 1 every cycle:
  - hsync period is 800 cycles, low for 96.
  - vsync is low for 2 lines every 525.
  - `vga_de` is high for 640 of each 800 for the first 480 lines.
- Write 3'b101 to address 161 (row 1, col 1 at SCALE_LOG2 = 2):
  - `vga_rgb` = 101 for screen pixels x 4..7, y 4..7.
  - `vga_rgb` = 0 elsewhere, with fill 0.
- `pix_en` toggling every other `clk`: outputs hold between enables, and the hsync period is 1600 `clk` cycles.
- Write to address 19200 (= FB_DEPTH): RAM is unchanged; a readback scan shows no pixel altered.
- Assert `reset` at hcnt = 300, vcnt = 200:
  - Outputs go to reset values before the next edge.
  - `frame_start` fires on the first `pix_en` after release.
- With `VGA_FB_VBLANK_IRQ_EN`:
  - `vblank_irq` rises at the stage-2 line 480 boundary.
  - `irq_clr` coinciding with that set leaves it high; a later `irq_clr` clears it.
